// File: rtl/regfile_dump_load.sv
// Debug/bring-up port for the CPU register file: dumps all registers as a byte
// stream with a trailing XOR checksum, or loads them from a stream and checks it.
module regfile_dump_load #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_dump,
    input  logic          start_load,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic          csum_err,
    output logic [AW-1:0] rf_rs_addr,
    input  logic [DW-1:0] rf_rs_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_rd_addr,
    output logic [DW-1:0] rf_wdata,
    output logic [DW-1:0] tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);

    // Both streams: a byte moves on a rising edge where valid && ready are both
    // high; the sender holds data stable while valid is high and ready is low.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D_FETCH = 3'd1,
        D_SEND  = 3'd2,
        D_CSUM  = 3'd3,
        L_DATA  = 3'd4,
        L_CSUM  = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [DW-1:0] csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            csum     <= '0;
            tx_data  <= '0;
            csum_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_dump || start_load) begin
                        state    <= start_dump ? D_FETCH : L_DATA;
                        idx      <= '0;
                        csum     <= '0;
                        csum_err <= 1'b0;
                    end
                end
                D_FETCH: begin
                    tx_data <= rf_rs_data;
                    csum    <= csum ^ rf_rs_data;
                    state   <= D_SEND;
                end
                D_SEND: begin
                    if (tx_ready) begin
                        // Terminal compare before increment, so idx never wraps.
                        if (idx == LAST) begin
                            tx_data <= csum;
                            state   <= D_CSUM;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= D_FETCH;
                        end
                    end
                end
                D_CSUM: begin
                    if (tx_ready) state <= DONE;
                end
                L_DATA: begin
                    if (rx_valid) begin
                        csum <= csum ^ rx_data;
                        if (idx == LAST) state <= L_CSUM;
                        else             idx   <= idx + 1'b1;
                    end
                end
                L_CSUM: begin
                    if (rx_valid) begin
                        csum_err <= (rx_data != csum);
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and register-file controls are decoded from the registered state.
    assign busy       = (state != IDLE);
    assign cpu_hold   = busy;
    assign done       = (state == DONE);
    assign tx_valid   = (state == D_SEND) || (state == D_CSUM);
    assign rx_ready   = (state == L_DATA) || (state == L_CSUM);
    assign rf_rs_addr = (state == D_FETCH) ? idx : '0;
    assign rf_we      = (state == L_DATA) && rx_valid;
    assign rf_rd_addr = rf_we ? idx : '0;
    assign rf_wdata   = rf_we ? rx_data : '0;

endmodule

// File: tb/tb_regfile_dump_load.sv
// Bench for regfile_dump_load: a small register file model around the DUT and a
// stream-level reference that predicts dump bytes, writes and checksum errors.
module tb_regfile_dump_load;
    localparam int NREGS = 8;
    localparam int AW    = 3;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset, start_dump, start_load;
    logic          busy, cpu_hold, done, csum_err;
    logic [AW-1:0] rf_rs_addr, rf_rd_addr;
    logic [DW-1:0] rf_rs_data, rf_wdata, tx_data, rx_data;
    logic          rf_we, tx_valid, tx_ready, rx_valid, rx_ready;

    regfile_dump_load #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start_dump(start_dump), .start_load(start_load),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .csum_err(csum_err),
        .rf_rs_addr(rf_rs_addr), .rf_rs_data(rf_rs_data), .rf_we(rf_we),
        .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- register file environment ----------------
    logic [DW-1:0] rf_mem [NREGS];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)     rf_mem[pre_addr]   <= pre_data;
        else if (rf_we) rf_mem[rf_rd_addr] <= rf_wdata;
    end
    assign rf_rs_data = rf_mem[rf_rs_addr];

    // ---------------- reference model and scoreboard ----------------
    logic [DW-1:0]    model_regs [NREGS];
    logic [DW-1:0]    exp_q [$];
    logic [AW+DW-1:0] exp_wr_q [$];
    int mode = 0;   // 0 idle, 1 dump expected, 2 load expected
    int done_cnt = 0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [DW-1:0] xor_all(input logic [DW-1:0] b [NREGS]);
        logic [DW-1:0] x;
        x = '0;
        for (int i = 0; i < NREGS; i++) x ^= b[i];
        return x;
    endfunction

    // Per-cycle compare process, sampled on the falling edge.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_tx = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            check("hold_eq_busy", cpu_hold, busy);
            if (mode != 2) check("no_write_outside_load", rf_we, 1'b0);
            if (mode != 1) check("no_tx_outside_dump", tx_valid, 1'b0);
            if (prev_stall && tx_valid) check("tx_stable_in_stall", tx_data, prev_tx);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) fail_now("tx_extra_byte");
                else check("tx_byte", tx_data, exp_q.pop_front());
            end
            if (rf_we) begin
                if (exp_wr_q.size() == 0) fail_now("extra_write");
                else check("write_addr_data", {rf_rd_addr, rf_wdata}, exp_wr_q.pop_front());
            end
            if (done) done_cnt++;
            prev_stall <= tx_valid && !tx_ready;
            prev_tx    <= tx_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [DW-1:0] b [NREGS]);
        for (int i = 0; i < NREGS; i++) begin
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = b[i];
            model_regs[i] = b[i];
            tick();
        end
        pre_we = 1'b0;
    endtask

    task automatic expect_dump();
        exp_q.delete();
        for (int i = 0; i < NREGS; i++) exp_q.push_back(model_regs[i]);
        exp_q.push_back(xor_all(model_regs));
    endtask

    // rmode: 0 ready held high, 1 ready toggling from 0, 2 random ready
    task automatic run_dump(input int rmode, input bit both, input bit inj_load);
        int cyc;
        int d0;
        expect_dump();
        d0 = done_cnt;
        mode = 1;
        start_dump = 1'b1; start_load = both;
        tx_ready = (rmode == 0);
        tick();
        start_dump = 1'b0; start_load = 1'b0;
        cyc = 1;
        check("dump_clears_err", csum_err, 1'b0);
        while (!done && cyc < 400) begin
            check("busy_during_dump", busy, 1'b1);
            case (rmode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            start_load = inj_load && (cyc == 5);
            tick();
            cyc++;
        end
        start_load = 1'b0;
        if (!done) fail_now("dump_timeout");
        else if (rmode == 0) check("dump_done_cycle", cyc, 18);
        tick();
        tx_ready = 1'b0;
        check("dump_done_one_cycle", done, 1'b0);
        check("dump_idle_after", busy, 1'b0);
        check("dump_done_pulses", done_cnt - d0, 1);
        check("dump_bytes_left", exp_q.size(), 0);
        check("idle_rs_addr", rf_rs_addr, 0);
        mode = 0;
    endtask

    // vmode: 0 valid held high, 1 random valid
    task automatic run_load(input logic [DW-1:0] b [NREGS], input logic [DW-1:0] cs,
                            input int vmode);
        int   cyc;
        int   p;
        int   d0;
        logic hs;
        logic exp_err;
        exp_wr_q.delete();
        for (int i = 0; i < NREGS; i++) begin
            exp_wr_q.push_back({AW'(i), b[i]});
            model_regs[i] = b[i];
        end
        exp_err = (cs != xor_all(b));
        d0 = done_cnt;
        mode = 2;
        p = 0;
        start_load = 1'b1; rx_valid = 1'b0;
        tick();
        start_load = 1'b0;
        cyc = 1;
        check("load_clears_err", csum_err, 1'b0);
        while (!done && cyc < 400) begin
            check("busy_during_load", busy, 1'b1);
            rx_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rx_data  = (p < NREGS) ? b[p] : cs;
            hs = rx_valid && rx_ready;
            tick();
            cyc++;
            if (hs) p++;
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
        if (!done) fail_now("load_timeout");
        else begin
            if (vmode == 0) check("load_done_cycle", cyc, 10);
            check("load_csum_err", csum_err, exp_err);
        end
        tick();
        check("load_done_one_cycle", done, 1'b0);
        check("load_idle_after", busy, 1'b0);
        check("load_err_sticky", csum_err, exp_err);
        check("load_done_pulses", done_cnt - d0, 1);
        check("load_writes_left", exp_wr_q.size(), 0);
        for (int i = 0; i < NREGS; i++) check("load_reg_contents", rf_mem[i], model_regs[i]);
        mode = 0;
    endtask

    task automatic reset_mid_dump();
        int d0;
        expect_dump();
        mode = 1;
        start_dump = 1'b1; tx_ready = 1'b1;
        tick();
        start_dump = 1'b0;
        repeat (7) tick();
        check("rst_pre_valid", tx_valid, 1'b1);
        check("rst_pre_byte", tx_data, model_regs[3]);
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        tx_ready = 1'b0;
        exp_q.delete();
        mode = 0;
        tick();
        check("rst_no_done_pulse", done_cnt - d0, 0);
    endtask

    // ---------------- main sequence ----------------
    logic [DW-1:0] patt [NREGS];
    logic [DW-1:0] rnd [NREGS];
    logic [DW-1:0] cs;

    initial begin
        reset = 1'b1; start_dump = 1'b0; start_load = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) tick();
        check("rst_busy0", busy, 1'b0);
        check("rst_hold0", cpu_hold, 1'b0);
        check("rst_done0", done, 1'b0);
        check("rst_err0", csum_err, 1'b0);
        check("rst_txv0", tx_valid, 1'b0);
        check("rst_rxr0", rx_ready, 1'b0);
        check("rst_we0", rf_we, 1'b0);
        check("rst_txd0", tx_data, 0);
        check("rst_addr0", {rf_rs_addr, rf_rd_addr, rf_wdata}, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NREGS; i++) patt[i] = 8'((i + 1) * 17);
        check("model_xor_11_88", xor_all(patt), 8'h88);
        preload(patt);
        run_dump(0, 1'b0, 1'b0);
        run_dump(1, 1'b0, 1'b0);

        for (int i = 0; i < NREGS; i++) patt[i] = 8'(8'hA0 + i);
        check("model_xor_a0_a7", xor_all(patt), 8'h00);
        run_load(patt, 8'h00, 0);

        for (int i = 0; i < NREGS; i++) patt[i] = 8'(i + 1);
        check("model_xor_01_08", xor_all(patt), 8'h08);
        run_load(patt, 8'hFF, 0);
        check("err_before_dump", csum_err, 1'b1);
        run_dump(0, 1'b0, 1'b0);

        run_dump(0, 1'b1, 1'b0);
        run_dump(0, 1'b0, 1'b1);

        reset_mid_dump();
        run_dump(0, 1'b0, 1'b0);

        repeat (6) begin
            for (int i = 0; i < NREGS; i++) rnd[i] = 8'($urandom_range(0, 255));
            cs = ($urandom_range(0, 1) == 1) ? xor_all(rnd) : 8'($urandom_range(0, 255));
            run_load(rnd, cs, 1);
            run_dump(2, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
